// File: rtl/screen_scheduler.sv
// VGA screen controller: start-button hit test, menu/game state machine and
// a frame-synchronous pixel-stream multiplexer with BRAM-aligned blanking.
module screen_scheduler #(
  parameter logic [9:0] BTN_X0   = 10'd240,
  parameter logic [9:0] BTN_X1   = 10'd399,
  parameter logic [9:0] BTN_Y0   = 10'd300,
  parameter logic [9:0] BTN_Y1   = 10'd359,
  parameter logic [9:0] V_ACTIVE = 10'd480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        valid,
  input  logic [9:0]  mouse_x,
  input  logic [9:0]  mouse_y,
  input  logic        mouse_left,
  input  logic        back_req,
  input  logic [11:0] pixel_menu_in,
  input  logic [11:0] pixel_game_in,
  output logic        mouse_on_start_button,
  output logic        screen_sel,
  output logic        game_start,
  output logic [11:0] pixel_out
);

  typedef enum logic [2:0] {
    MENU      = 3'd0,
    ARMED     = 3'd1,
    PEND_GAME = 3'd2,
    GAME      = 3'd3,
    PEND_MENU = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic        mouse_left_d_reg;
  logic        on_btn_reg, on_btn_next;
  logic        screen_sel_reg, screen_sel_next;
  logic        game_start_reg, game_start_next;
  logic        valid_d_reg, sel_d_reg;
  logic [11:0] pixel_reg;

  logic hit, press_evt, release_evt, frame_tick;

  assign hit = (mouse_x >= BTN_X0) && (mouse_x <= BTN_X1) &&
               (mouse_y >= BTN_Y0) && (mouse_y <= BTN_Y1);
  assign press_evt   = mouse_left & ~mouse_left_d_reg;
  assign release_evt = ~mouse_left & mouse_left_d_reg;
  assign frame_tick  = (h_cnt == 10'd0) && (v_cnt == V_ACTIVE);

  // State register plus the registered outputs decoded from it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= MENU;
      mouse_left_d_reg <= 1'b0;
      on_btn_reg       <= 1'b0;
      screen_sel_reg   <= 1'b0;
      game_start_reg   <= 1'b0;
    end else begin
      state_reg        <= state_next;
      mouse_left_d_reg <= mouse_left;
      on_btn_reg       <= on_btn_next;
      screen_sel_reg   <= screen_sel_next;
      game_start_reg   <= game_start_next;
    end
  end

  // Events win over a coincident frame_tick, so a PEND state always waits a full frame
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      MENU:      if (press_evt && on_btn_reg) state_next = ARMED;
      ARMED: begin
        if (release_evt && on_btn_reg) state_next = PEND_GAME;
        else if (!on_btn_reg)          state_next = MENU;
      end
      PEND_GAME: if (frame_tick) state_next = GAME;
      GAME:      if (back_req)   state_next = PEND_MENU;
      PEND_MENU: if (frame_tick) state_next = MENU;
      default:   state_next = MENU;
    endcase
  end

  always_comb begin
    on_btn_next     = hit && (state_reg == MENU || state_reg == ARMED);
    screen_sel_next = (state_next == GAME) || (state_next == PEND_MENU);
    game_start_next = (state_reg == PEND_GAME) && frame_tick;
  end

  // Pixel inputs arrive one cycle late, so valid and select are delayed to match
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_d_reg <= 1'b0;
      sel_d_reg   <= 1'b0;
      pixel_reg   <= 12'h000;
    end else begin
      valid_d_reg <= valid;
      sel_d_reg   <= screen_sel_reg;
      pixel_reg   <= valid_d_reg ? (sel_d_reg ? pixel_game_in : pixel_menu_in) : 12'h000;
    end
  end

  assign mouse_on_start_button = on_btn_reg;
  assign screen_sel            = screen_sel_reg;
  assign game_start            = game_start_reg;
  assign pixel_out             = pixel_reg;

endmodule

// File: tb/tb_screen_scheduler.sv
// Directed bench for screen_scheduler: hover, click, cancel, return and pixel path.
module tb_screen_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  h_cnt, v_cnt;
  logic        valid;
  logic [9:0]  mouse_x, mouse_y;
  logic        mouse_left;
  logic        back_req;
  logic [11:0] pixel_menu_in, pixel_game_in;
  logic        mouse_on_start_button, screen_sel, game_start;
  logic [11:0] pixel_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  screen_scheduler dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .h_cnt                 (h_cnt),
    .v_cnt                 (v_cnt),
    .valid                 (valid),
    .mouse_x               (mouse_x),
    .mouse_y               (mouse_y),
    .mouse_left            (mouse_left),
    .back_req              (back_req),
    .pixel_menu_in         (pixel_menu_in),
    .pixel_game_in         (pixel_game_in),
    .mouse_on_start_button (mouse_on_start_button),
    .screen_sel            (screen_sel),
    .game_start            (game_start),
    .pixel_out             (pixel_out)
  );

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse();
    h_cnt = 10'd0;
    v_cnt = 10'd480;
    tick();
    h_cnt = 10'd5;
    v_cnt = 10'd100;
  endtask

  task automatic set_mouse(input int x, input int y);
    mouse_x = 10'(x);
    mouse_y = 10'(y);
  endtask

  initial begin
    rst_n         = 1'b0;
    h_cnt         = 10'd5;
    v_cnt         = 10'd100;
    valid         = 1'b0;
    mouse_left    = 1'b1;
    back_req      = 1'b0;
    pixel_menu_in = 12'hABC;
    pixel_game_in = 12'h123;
    set_mouse(300, 320);
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_flag", {11'd0, mouse_on_start_button}, 12'd0);
    chk("rst_sel",  {11'd0, screen_sel}, 12'd0);
    chk("rst_gs",   {11'd0, game_start}, 12'd0);
    chk("rst_pix",  pixel_out, 12'h000);
    tick();
    chk("rst_flag_after", {11'd0, mouse_on_start_button}, 12'd1);
    mouse_left = 1'b0;
    tick();

    // Hover boundaries
    set_mouse(239, 320); tick(); chk("hover_239_320", {11'd0, mouse_on_start_button}, 12'd0);
    set_mouse(240, 320); tick(); chk("hover_240_320", {11'd0, mouse_on_start_button}, 12'd1);
    set_mouse(399, 359); tick(); chk("hover_399_359", {11'd0, mouse_on_start_button}, 12'd1);
    set_mouse(400, 359); tick(); chk("hover_400_359", {11'd0, mouse_on_start_button}, 12'd0);

    // Pixel path in menu
    valid = 1'b1;
    tick(); tick();
    chk("pix_menu", pixel_out, 12'hABC);
    valid = 1'b0;
    tick();
    chk("pix_latency", pixel_out, 12'hABC);
    tick();
    chk("pix_blank", pixel_out, 12'h000);

    // Cancel: press on button, drag off, release
    set_mouse(300, 320); tick();
    mouse_left = 1'b1; tick();
    set_mouse(100, 100); tick(); tick();
    mouse_left = 1'b0; tick();
    frame_pulse();
    chk("cancel1_sel", {11'd0, screen_sel}, 12'd0);
    chk("cancel1_gs",  {11'd0, game_start}, 12'd0);

    // Cancel: press off button, move on, release
    mouse_left = 1'b1; tick(); tick();
    set_mouse(300, 320); tick(); tick();
    mouse_left = 1'b0; tick();
    frame_pulse();
    chk("cancel2_sel", {11'd0, screen_sel}, 12'd0);
    chk("cancel2_gs",  {11'd0, game_start}, 12'd0);

    // Click: press and release on the button
    mouse_left = 1'b1; tick();
    mouse_left = 1'b0; tick();
    chk("click_sel_pend", {11'd0, screen_sel}, 12'd0);
    chk("click_gs_pend",  {11'd0, game_start}, 12'd0);
    tick(); tick();
    chk("click_sel_wait", {11'd0, screen_sel}, 12'd0);
    frame_pulse();
    chk("click_sel_game", {11'd0, screen_sel}, 12'd1);
    chk("click_gs_pulse", {11'd0, game_start}, 12'd1);
    tick();
    chk("click_gs_end",   {11'd0, game_start}, 12'd0);
    chk("game_sel_hold",  {11'd0, screen_sel}, 12'd1);
    chk("game_flag_off",  {11'd0, mouse_on_start_button}, 12'd0);

    // Pixel path in game
    valid = 1'b1;
    tick(); tick();
    chk("pix_game", pixel_out, 12'h123);
    valid = 1'b0;

    // Return: back_req coincident with frame_tick waits one more frame
    back_req = 1'b1;
    frame_pulse();
    back_req = 1'b0;
    chk("ret_sel_pend", {11'd0, screen_sel}, 12'd1);
    tick();
    chk("ret_sel_wait", {11'd0, screen_sel}, 12'd1);
    frame_pulse();
    chk("ret_sel_menu", {11'd0, screen_sel}, 12'd0);
    chk("ret_gs",       {11'd0, game_start}, 12'd0);
    tick();
    chk("ret_flag_on",  {11'd0, mouse_on_start_button}, 12'd1);

    // back_req in menu has no effect
    back_req = 1'b1; tick();
    back_req = 1'b0; tick();
    frame_pulse();
    chk("menu_backreq_sel", {11'd0, screen_sel}, 12'd0);
    chk("menu_backreq_gs",  {11'd0, game_start}, 12'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
